// File: rtl/fll_regbus_model.sv
// fll_regbus_model: register-bus model of an FLL configuration block.
// It has STATUS, CFG1 (target multiplier and divider), CFG2 (lock cycles) and RELOCK registers.
// The current multiplier slews one step per cycle toward the target, then settles and locks.
//
// FLL states:
//   state  | meaning
//   LOCKED | lock_o high, mult_o equals target
//   SLEW   | mult_o moving one step per cycle toward target
//   SETTLE | mult_o at target, settle counter running down to 0
module fll_regbus_model #(
    parameter int unsigned AddrWidth       = 48,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned WaitCycles      = 0,
    parameter logic [15:0] ResetMult       = 16'h0020,
    parameter logic [15:0] ResetLockCycles = 16'h0010
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic                 reg_ready_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 lock_o,
    output logic [15:0]          mult_o
);

    if (DataWidth != 32) begin : g_bad_data_width
        $error("fll_regbus_model: DataWidth must be 32");
    end
    if (WaitCycles > 15) begin : g_bad_wait_cycles
        $error("fll_regbus_model: WaitCycles must be 0..15");
    end

    localparam int unsigned WaitM1   = (WaitCycles > 0) ? WaitCycles - 1 : 0;
    localparam logic [3:0]  WaitLoad = WaitM1[3:0];

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT,
        BUS_RESP
    } bus_state_e;

    typedef enum logic [1:0] {
        FLL_LOCKED,
        FLL_SLEW,
        FLL_SETTLE
    } fll_state_e;

    bus_state_e bus_state_q, bus_state_d;
    fll_state_e fll_state_q, fll_state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [15:0] target_q, target_d;
    logic [3:0]  div_q, div_d;
    logic [15:0] lock_cycles_q, lock_cycles_d;
    logic [15:0] mult_q, mult_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [31:0] relock_q, relock_d;

    logic [3:0]  addr_lo;
    logic        acc_err;
    logic [31:0] rd_mux;
    logic        wr_commit;
    logic        cfg1_sel;
    logic        cfg2_sel;
    logic        cfg1_event;
    logic [15:0] mult_step;
    logic        unused_bits;

    assign addr_lo     = reg_addr_i[3:0];
    assign unused_bits = ^{reg_addr_i[AddrWidth-1:4], reg_wdata_i[31:20]};

    // Decode the held request: error classification and read data mux.
    always_comb begin
        acc_err = 1'b0;
        rd_mux  = 32'h0;
        if (addr_lo[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end else if (reg_write_i && ((addr_lo[3:2] == 2'd0) || (addr_lo[3:2] == 2'd3))) begin
            acc_err = 1'b1;
        end
        case (addr_lo[3:2])
            2'd0:    rd_mux = {mult_q, 15'h0, (fll_state_q == FLL_LOCKED)};
            2'd1:    rd_mux = {12'h0, div_q, target_q};
            2'd2:    rd_mux = {16'h0, lock_cycles_q};
            default: rd_mux = relock_q;
        endcase
    end

    // Bus handshake: accept, count wait states, then a single registered ready pulse.
    always_comb begin
        bus_state_d = bus_state_q;
        wait_cnt_d  = wait_cnt_q;
        ready_d     = 1'b0;
        rdata_d     = 32'h0;
        error_d     = 1'b0;
        case (bus_state_q)
            BUS_IDLE: begin
                if (reg_valid_i) begin
                    if (WaitCycles == 0) begin
                        bus_state_d = BUS_RESP;
                        ready_d     = 1'b1;
                    end else begin
                        bus_state_d = BUS_WAIT;
                        wait_cnt_d  = WaitLoad;
                    end
                end
            end
            BUS_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    bus_state_d = BUS_RESP;
                    ready_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                bus_state_d = BUS_IDLE;
            end
        endcase
        if (ready_d) begin
            error_d = acc_err;
            rdata_d = (!reg_write_i && !acc_err) ? rd_mux : 32'h0;
        end
    end

    // Register writes commit in the ready cycle, byte-wise under the strobes.
    always_comb begin
        wr_commit     = (bus_state_q == BUS_RESP) && reg_write_i && !acc_err;
        cfg1_sel      = wr_commit && (addr_lo[3:2] == 2'd1);
        cfg2_sel      = wr_commit && (addr_lo[3:2] == 2'd2);
        cfg1_event    = cfg1_sel && (reg_wstrb_i != 4'h0);
        target_d      = target_q;
        div_d         = div_q;
        lock_cycles_d = lock_cycles_q;
        if (cfg1_sel) begin
            if (reg_wstrb_i[0]) target_d[7:0]  = reg_wdata_i[7:0];
            if (reg_wstrb_i[1]) target_d[15:8] = reg_wdata_i[15:8];
            if (reg_wstrb_i[2]) div_d          = reg_wdata_i[19:16];
        end
        if (cfg2_sel) begin
            if (reg_wstrb_i[0]) lock_cycles_d[7:0]  = reg_wdata_i[7:0];
            if (reg_wstrb_i[1]) lock_cycles_d[15:8] = reg_wdata_i[15:8];
        end
    end

    // FLL next state: slew toward the post-write target, settle, lock, count relocks.
    always_comb begin
        fll_state_d  = fll_state_q;
        mult_d       = mult_q;
        settle_cnt_d = settle_cnt_q;
        relock_d     = relock_q;
        mult_step    = (target_d > mult_q) ? (mult_q + 16'd1) : (mult_q - 16'd1);
        case (fll_state_q)
            FLL_LOCKED: begin
                if (cfg1_event && (target_d != mult_q)) begin
                    fll_state_d = FLL_SLEW;
                    if (relock_q != 32'hFFFF_FFFF) relock_d = relock_q + 32'd1;
                end
            end
            FLL_SLEW: begin
                if (target_d == mult_q) begin
                    fll_state_d  = FLL_SETTLE;
                    settle_cnt_d = lock_cycles_q;
                end else begin
                    mult_d = mult_step;
                end
            end
            default: begin
                if (cfg1_event) begin
                    if (target_d == mult_q) begin
                        settle_cnt_d = lock_cycles_q;
                    end else begin
                        fll_state_d = FLL_SLEW;
                        mult_d      = mult_step;
                    end
                end else if (settle_cnt_q == 16'd0) begin
                    fll_state_d = FLL_LOCKED;
                end else begin
                    settle_cnt_d = settle_cnt_q - 16'd1;
                end
            end
        endcase
    end

    // State registers; reset aborts any access or slew in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_state_q   <= BUS_IDLE;
            wait_cnt_q    <= 4'd0;
            ready_q       <= 1'b0;
            rdata_q       <= 32'h0;
            error_q       <= 1'b0;
            target_q      <= ResetMult;
            div_q         <= 4'h1;
            lock_cycles_q <= ResetLockCycles;
            fll_state_q   <= FLL_LOCKED;
            mult_q        <= ResetMult;
            settle_cnt_q  <= 16'd0;
            relock_q      <= 32'd0;
        end else begin
            bus_state_q   <= bus_state_d;
            wait_cnt_q    <= wait_cnt_d;
            ready_q       <= ready_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
            target_q      <= target_d;
            div_q         <= div_d;
            lock_cycles_q <= lock_cycles_d;
            fll_state_q   <= fll_state_d;
            mult_q        <= mult_d;
            settle_cnt_q  <= settle_cnt_d;
            relock_q      <= relock_d;
        end
    end

    assign reg_ready_o = ready_q;
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;
    assign lock_o      = (fll_state_q == FLL_LOCKED);
    assign mult_o      = mult_q;

endmodule

// File: tb/tb_fll_regbus_model.sv
// Testbench for fll_regbus_model: a zero-wait instance driven through a scoreboard,
// plus a three-wait-state instance for latency and reset-abort behaviour.
module tb_fll_regbus_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, a_valid, a_write, a_ready, a_error, a_lock;
    logic [47:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic [15:0] a_mult;

    logic        rst_b, b_valid, b_write, b_ready, b_error, b_lock;
    logic [47:0] b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_wstrb;
    logic [15:0] b_mult;

    fll_regbus_model #(.WaitCycles(0)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .reg_valid_i(a_valid), .reg_write_i(a_write),
        .reg_addr_i(a_addr), .reg_wdata_i(a_wdata), .reg_wstrb_i(a_wstrb),
        .reg_ready_o(a_ready), .reg_rdata_o(a_rdata), .reg_error_o(a_error),
        .lock_o(a_lock), .mult_o(a_mult)
    );

    fll_regbus_model #(.WaitCycles(3)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .reg_valid_i(b_valid), .reg_write_i(b_write),
        .reg_addr_i(b_addr), .reg_wdata_i(b_wdata), .reg_wstrb_i(b_wstrb),
        .reg_ready_o(b_ready), .reg_rdata_o(b_rdata), .reg_error_o(b_error),
        .lock_o(b_lock), .mult_o(b_mult)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Scoreboard: every ready pulse on dut_a retires exactly one expected response.
    always @(negedge clk) begin : sb_monitor
        exp_t e;
        if (a_ready === 1'b1) begin
            check_eq("sb_pending", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq({e.tag, "_rdata"}, a_rdata, e.rdata);
                check_eq({e.tag, "_err"}, 32'(a_error), 32'(e.err));
            end
        end
    end

    // Caller sits on a negedge; returns on the negedge after the ready cycle.
    task automatic a_xfer(input string tag, input logic wr, input logic [47:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        bit seen;
        sb.push_back('{tag, exp_rdata, exp_err});
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (a_ready === 1'b1) seen = 1'b1;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd1);
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(a_ready), 32'd0);
        a_valid = 1'b0; a_write = 1'b0; a_wstrb = 4'h0;
    endtask

    task automatic b_xfer(input logic wr, input logic [47:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        bit seen;
        b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata; b_wstrb = 4'hF;
        lat = 0; seen = 1'b0; rdata = 32'h0; err = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (b_ready === 1'b1) begin
                seen = 1'b1; rdata = b_rdata; err = b_error;
            end
        end
        @(negedge clk);
        b_valid = 1'b0; b_write = 1'b0;
    endtask

    task automatic a_reset();
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          low, steps, bad, lat, rdycnt;
        logic [15:0] prev;
        logic [31:0] rd;
        logic        er;

        a_valid = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        check_eq("rst_ready", 32'(a_ready), 32'd0);
        check_eq("rst_rdata", a_rdata, 32'h0);
        check_eq("rst_error", 32'(a_error), 32'd0);
        check_eq("rst_lock", 32'(a_lock), 32'd1);
        check_eq("rst_mult", 32'(a_mult), 32'h20);

        a_xfer("rd_status", 0, 48'h0, 0, 4'h0, 32'h0020_0001, 0);
        a_xfer("rd_cfg1",   0, 48'h4, 0, 4'h0, 32'h0001_0020, 0);
        a_xfer("rd_cfg2",   0, 48'h8, 0, 4'h0, 32'h0000_0010, 0);
        a_xfer("rd_relock", 0, 48'hC, 0, 4'h0, 32'h0000_0000, 0);

        // Slew 0x20 -> 0x24: 5 SLEW cycles (incl. the one at target) + 4 SETTLE = 9 unlocked.
        a_xfer("wr_cfg2", 1, 48'h8, 32'h0000_0003, 4'hF, 0, 0);
        a_xfer("wr_cfg1", 1, 48'h4, 32'h0001_0024, 4'hF, 0, 0);
        check_eq("lock_fall", 32'(a_lock), 32'd0);
        low = 1; steps = 0; bad = 0; prev = a_mult;
        for (int i = 0; i < 100 && a_lock == 1'b0; i++) begin
            @(negedge clk);
            if (a_lock == 1'b0) low++;
            if (a_mult != prev) begin
                if (a_mult != prev + 16'd1) bad++;
                steps++;
                prev = a_mult;
            end
        end
        check_eq("slew_steps", 32'(steps), 32'd4);
        check_eq("slew_bad_steps", 32'(bad), 32'd0);
        check_eq("lock_low_cycles", 32'(low), 32'd9);
        check_eq("lock_rise", 32'(a_lock), 32'd1);
        check_eq("mult_locked", 32'(a_mult), 32'h24);
        a_xfer("rd_relock1", 0, 48'hC, 0, 4'h0, 32'd1, 0);
        a_xfer("rd_status1", 0, 48'h0, 0, 4'h0, 32'h0024_0001, 0);

        // Reversal: the write commits while mult_o is 0x22.
        a_reset();
        a_xfer("wr_cfg2_r", 1, 48'h8, 32'h0000_0003, 4'hF, 0, 0);
        a_xfer("wr_cfg1_r", 1, 48'h4, 32'h0001_0024, 4'hF, 0, 0);
        for (int i = 0; i < 10 && a_mult != 16'h21; i++) @(negedge clk);
        check_eq("poll_21", 32'(a_mult), 32'h21);
        a_xfer("wr_cfg1_rev", 1, 48'h4, 32'h0001_0020, 4'hF, 0, 0);
        check_eq("rev_mult", 32'(a_mult), 32'h21);
        low = 1;
        for (int i = 0; i < 100 && a_lock == 1'b0; i++) begin
            @(negedge clk);
            if (a_lock == 1'b0) low++;
        end
        check_eq("rev_low_cycles", 32'(low), 32'd6);
        check_eq("rev_lock", 32'(a_lock), 32'd1);
        check_eq("rev_mult_final", 32'(a_mult), 32'h20);
        a_xfer("rd_relock_rev", 0, 48'hC, 0, 4'h0, 32'd1, 0);

        // Byte strobes: only byte 1 written, target 0x0020 -> 0x0120.
        a_xfer("wr_cfg1_b1", 1, 48'h4, 32'h0000_0100, 4'b0010, 0, 0);
        check_eq("b1_lock_fall", 32'(a_lock), 32'd0);
        a_xfer("rd_cfg1_b1", 0, 48'h4, 0, 4'h0, 32'h0001_0120, 0);
        for (int i = 0; i < 2000 && a_lock == 1'b0; i++) @(negedge clk);
        check_eq("b1_lock", 32'(a_lock), 32'd1);
        check_eq("b1_mult", 32'(a_mult), 32'h120);
        a_xfer("wr_cfg1_s0", 1, 48'h4, 32'hFFFF_FFFF, 4'h0, 0, 0);
        check_eq("s0_lock", 32'(a_lock), 32'd1);
        a_xfer("wr_cfg1_eq", 1, 48'h4, 32'h0001_0120, 4'hF, 0, 0);
        check_eq("eq_lock", 32'(a_lock), 32'd1);
        a_xfer("rd_cfg1_s0", 0, 48'h4, 0, 4'h0, 32'h0001_0120, 0);
        a_xfer("rd_relock2", 0, 48'hC, 0, 4'h0, 32'd2, 0);

        // Error responses leave every register untouched.
        a_xfer("wr_status", 1, 48'h0, 32'hFFFF_FFFF, 4'hF, 0, 1);
        a_xfer("wr_relock", 1, 48'hC, 32'hFFFF_FFFF, 4'hF, 0, 1);
        a_xfer("rd_mis5",   0, 48'h5, 0, 4'h0, 0, 1);
        a_xfer("wr_mis6",   1, 48'h6, 32'h0000_0055, 4'hF, 0, 1);
        a_xfer("rd_status2", 0, 48'h0, 0, 4'h0, 32'h0120_0001, 0);
        a_xfer("rd_relock3", 0, 48'hC, 0, 4'h0, 32'd2, 0);
        a_xfer("rd_cfg2_3",  0, 48'h8, 0, 4'h0, 32'd3, 0);
        a_xfer("rd_alias",   0, 48'h1234_0000_0004, 0, 4'h0, 32'h0001_0120, 0);

        // Three wait states: ready four cycles after valid; reset aborts a pending access.
        b_xfer(0, 48'h8, 0, lat, rd, er);
        check_eq("b_rd_lat", 32'(lat), 32'd4);
        check_eq("b_rd_data", rd, 32'h10);
        check_eq("b_rd_err", 32'(er), 32'd0);
        b_xfer(1, 48'h4, 32'h0001_0030, lat, rd, er);
        check_eq("b_wr_lat", 32'(lat), 32'd4);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 48'h0;
        repeat (2) @(negedge clk);
        check_eq("b_pend_ready", 32'(b_ready), 32'd0);
        check_eq("b_pend_lock", 32'(b_lock), 32'd0);
        rst_b = 1'b1;
        #1;
        check_eq("b_abort_ready", 32'(b_ready), 32'd0);
        check_eq("b_abort_lock", 32'(b_lock), 32'd1);
        check_eq("b_abort_mult", 32'(b_mult), 32'h20);
        b_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        rdycnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_ready) rdycnt++;
        end
        check_eq("b_no_ready", 32'(rdycnt), 32'd0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fll_regbus_model.md
Name: fll_regbus_model

Overview:
- Behavioural register-bus model of a frequency-locked-loop (FLL) configuration block for simulation.
- It sits directly downstream of the AXI-Lite-to-regbus protocol converters on the fll_system, fll_periph and fll_hbm2e paths. It replaces the generic regbus memory model on those paths.
- It provides real FLL semantics to boot and driver software: a programmable multiplier that slews toward its target, a settle period, a lock flag, and a relock counter.

Parameters:
- AddrWidth, 48, regbus address width.
- DataWidth, 32, regbus data width; fixed at 32, any other value is an elaboration error.
- WaitCycles, 0, wait states inserted before ready on every access (0..15).
- ResetMult, 16'h0020, reset value of both the target and the current multiplier.
- ResetLockCycles, 16'h0010, reset value of the settle length.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- reg_valid_i  in  1  request valid.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  AddrWidth  byte address.
- reg_wdata_i  in  32  write data.
- reg_wstrb_i  in  4  byte strobes.
- reg_ready_o  out  1  access complete.
- reg_rdata_o  out  32  read data; valid while reg_ready_o is high.
- reg_error_o  out  1  access error; valid while reg_ready_o is high.
- lock_o  out  1  FLL locked.
- mult_o  out  16  current multiplier.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset rst_i is asynchronous and active-high.
  - Reset values: reg_ready_o=0, reg_rdata_o=0, reg_error_o=0, lock_o=1, mult_o=ResetMult, FSM=LOCKED, relock count=0.
  - Reset asserted mid-access or mid-slew aborts immediately, with no response.
- Address decode:
  - Only reg_addr_i[3:0] is decoded; higher address bits alias.
  - reg_addr_i[1:0] != 0 is an error.
- Register map:
  - 0x0 STATUS, RO: [0] lock, [31:16] current multiplier.
  - 0x4 CFG1, RW: [15:0] target multiplier, [19:16] output divider, [31:20] read as 0 and writes ignored. Reset {12'h0, 4'h1, ResetMult}.
  - 0x8 CFG2, RW: [15:0] lock_cycles, [31:16] read as 0. Reset ResetLockCycles.
  - 0xC RELOCK, RO: [31:0] count of LOCKED-exit events, saturating at 32'hFFFF_FFFF.
- Handshake:
  - A request is accepted when reg_valid_i is high. A wait counter counts WaitCycles cycles.
  - reg_ready_o is then registered high for exactly 1 cycle. Latency is WaitCycles+1 cycles from valid to ready.
  - The requester holds valid, write, addr, wdata and wstrb stable until ready.
  - After ready the model is idle for 1 cycle. A next request with valid still high is accepted in the following cycle. The model never returns back-to-back ready.
  - Writes commit in the ready cycle and take byte-wise effect per wstrb; wstrb=0 is a legal no-op.
  - reg_rdata_o = 0 when not ready, on writes, and on errors.
- Error cases (error=1 in the ready cycle, no state change):
  - misaligned address;
  - write to STATUS or RELOCK.
- FSM states:
  - LOCKED: lock_o=1.
    - On a committed CFG1 write whose resulting target != mult_o: go to SLEW and increment RELOCK.
    - A CFG1 write whose target equals mult_o stays LOCKED, with no relock.
  - SLEW: lock_o=0. Each cycle mult_o moves one step (±1) toward the target. The cycle mult_o equals the target, load the settle counter with lock_cycles and go to SETTLE.
  - SETTLE: lock_o=0. Decrement the counter each cycle. When the counter is 0, go to LOCKED; lock_o rises the following cycle. lock_cycles=0 gives a 1-cycle SETTLE.
- Arithmetic:
  - The 16-bit multiplier never wraps; it steps by exactly 1.
  - The RELOCK increment saturates.
- CFG1 write during SLEW or SETTLE:
  - The target is updated; no relock increment.
  - If the new target != mult_o, go to (or stay in) SLEW.
  - If the new target equals mult_o, go to SETTLE with the counter reloaded.
- CFG2 write during SETTLE: takes effect only at the next counter load.
- STATUS read in the same cycle as a state transition returns the pre-transition (registered) values.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC with WaitCycles=0 -> rdata 0x0020_0001, 0x0001_0020, 0x0000_0010, 0x0; ready exactly 1 cycle after valid; error=0.
- Write CFG2=0x3, then CFG1 mult=0x0024 -> lock_o falls the cycle after ready. mult_o steps 0x21..0x24 over 4 cycles, SETTLE lasts 4 cycles, then lock_o=1. RELOCK reads 1.
- Mid-slew (mult_o=0x22), write CFG1 mult=0x0020 -> mult_o reverses to 0x21, 0x20, then settles and locks. RELOCK stays 1.
- Write CFG1 with wstrb=4'b0010, wdata=0x0000_0100 -> target becomes 0x0120 (from 0x0020); relock starts. wstrb=0 -> no change, no relock.
- Write to 0x0, write to 0xC, read 0x5 -> each returns error=1 and rdata=0; register contents unchanged.
- WaitCycles=3: ready 4 cycles after valid. Assert rst_i during a pending access -> ready never asserts; lock_o=1 and mult_o=0x0020 immediately.
